// File: rtl/sd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sd_scan_ctrl
//  Description : Sequencer and decimating front end for a bank of NUM
//                sigma-delta modulators. Holds the modulators in clear,
//                releases them, discards SETTLE clocks, counts ones per
//                channel over OSR clocks, then streams the per-channel
//                results out one channel at a time (valid/ready). The result
//                bank is double-buffered against the live counters, so in
//                continuous mode a new window integrates while the previous
//                one drains.
//  Ports       : clock, aclr_n        clock / async active-low reset
//                start, cont, abort   acquisition control
//                sd_in[NUM]           modulator bitstreams
//                mod_clr              clear to the modulator bank
//                busy                 acquisition active or results pending
//                res_valid/res_ready  result stream handshake
//                res_ch/res_data      channel index and ones count
//                res_code             signed 2*res_data - OSR
//                res_last             last channel of the bank presented
//                overrun              sticky: window lost to a busy drain
//  Revision    : 1.0  initial release
// ============================================================================
module sd_scan_ctrl #(
    parameter  int NUM    = 16,
    parameter  int OSR    = 256,
    parameter  int SETTLE = 4,
    localparam int CW     = $clog2(OSR + 1),
    localparam int c_chw  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [NUM-1:0]   sd_in,
    output logic             mod_clr,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [c_chw-1:0] res_ch,
    output logic [CW-1:0]    res_data,
    output logic [CW:0]      res_code,
    output logic             res_last,
    output logic             overrun
);

    localparam int               c_sw          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_sw-1:0]  c_settle_last = c_sw'(SETTLE - 1);
    localparam logic [CW-1:0]    c_integ_last  = CW'(OSR - 1);
    localparam logic [c_chw-1:0] c_ch_last     = c_chw'(NUM - 1);
    localparam logic [CW:0]      c_osr_code    = (CW + 1)'(OSR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_INTEG  = 2'd2
    } acq_t;

    typedef enum logic {
        ST_DIDLE = 1'b0,
        ST_DRAIN = 1'b1
    } drn_t;

    acq_t             r_acq;
    drn_t             r_drn;
    logic [c_sw-1:0]  r_scnt;
    logic [CW-1:0]    r_icnt;
    logic [CW-1:0]    r_cnt  [NUM];
    logic [CW-1:0]    r_bank [NUM];
    logic             r_mod_clr;
    logic             r_overrun;
    logic             r_valid;
    logic [c_chw-1:0] r_ch;

    logic             w_win_end;
    logic             w_load;

    // An abort in the window-end cycle cancels the window entirely, so it
    // neither loads the bank nor counts as an overrun.
    assign w_win_end = (r_acq == ST_INTEG) && (r_icnt == c_integ_last) && !abort;
    // The bank is only free once the previous results have fully drained.
    assign w_load    = w_win_end && (r_drn == ST_DIDLE);

    // ------------------------------------------------------------------
    // Acquisition sequencer: IDLE -> SETTLE -> INTEG (-> INTEG ...)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_acq     <= ST_IDLE;
            r_scnt    <= '0;
            r_icnt    <= '0;
            r_mod_clr <= 1'b1;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                r_cnt[i]  <= '0;
                r_bank[i] <= '0;
            end
        end else begin
            case (r_acq)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_acq     <= ST_SETTLE;
                        r_scnt    <= '0;
                        r_mod_clr <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        r_acq     <= ST_IDLE;
                        r_mod_clr <= 1'b1;
                        for (int i = 0; i < NUM; i++) r_cnt[i] <= '0;
                    end else if (r_scnt == c_settle_last) begin
                        r_acq  <= ST_INTEG;
                        r_icnt <= '0;
                    end else begin
                        r_scnt <= r_scnt + c_sw'(1);
                    end
                end

                ST_INTEG: begin
                    if (abort) begin
                        r_acq     <= ST_IDLE;
                        r_icnt    <= '0;
                        r_mod_clr <= 1'b1;
                        for (int i = 0; i < NUM; i++) r_cnt[i] <= '0;
                    end else begin
                        // The final sample is folded straight into the bank so
                        // the counters can restart with no gap cycle.
                        for (int i = 0; i < NUM; i++) begin
                            if (w_win_end)
                                r_cnt[i] <= '0;
                            else
                                r_cnt[i] <= r_cnt[i] + CW'(sd_in[i]);
                            if (w_load)
                                r_bank[i] <= r_cnt[i] + CW'(sd_in[i]);
                        end
                        if (w_win_end) begin
                            r_icnt <= '0;
                            if (!w_load)
                                r_overrun <= 1'b1;
                            if (!cont) begin
                                r_acq     <= ST_IDLE;
                                r_mod_clr <= 1'b1;
                            end
                        end else begin
                            r_icnt <= r_icnt + CW'(1);
                        end
                    end
                end

                default: begin
                    r_acq     <= ST_IDLE;
                    r_mod_clr <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drain sequencer: walks the bank out one channel per handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_drn   <= ST_DIDLE;
            r_valid <= 1'b0;
            r_ch    <= '0;
        end else begin
            case (r_drn)
                ST_DIDLE: begin
                    if (w_load) begin
                        r_drn   <= ST_DRAIN;
                        r_valid <= 1'b1;
                        r_ch    <= '0;
                    end
                end

                ST_DRAIN: begin
                    if (res_ready) begin
                        if (r_ch == c_ch_last) begin
                            r_drn   <= ST_DIDLE;
                            r_valid <= 1'b0;
                            r_ch    <= '0;
                        end else begin
                            r_ch <= r_ch + c_chw'(1);
                        end
                    end
                end

                default: begin
                    r_drn   <= ST_DIDLE;
                    r_valid <= 1'b0;
                    r_ch    <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mod_clr   = r_mod_clr;
    assign overrun   = r_overrun;
    assign res_valid = r_valid;
    assign res_ch    = r_ch;
    assign res_data  = r_bank[r_ch];
    // 2*count - OSR; modulo CW+1 bits this is exact because the true value
    // always lies in -OSR..+OSR, which fits the signed CW+1 range.
    assign res_code  = {res_data, 1'b0} - c_osr_code;
    assign res_last  = r_valid && (r_ch == c_ch_last);
    assign busy      = (r_acq != ST_IDLE) || r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_scan_ctrl
//  Description : Self-checking bench for sd_scan_ctrl (NUM=4, OSR=16,
//                SETTLE=2). Expected results are computed by summing the
//                driven bitstreams per window and queued; a negedge monitor
//                pops and compares on every result handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sd_scan_ctrl;

    localparam int NUM    = 4;
    localparam int OSR    = 16;
    localparam int SETTLE = 2;
    localparam int CW     = 5;

    logic           clock     = 1'b0;
    logic           aclr_n    = 1'b0;
    logic           start     = 1'b0;
    logic           cont      = 1'b0;
    logic           abort     = 1'b0;
    logic [NUM-1:0] sd_in     = '0;
    logic           res_ready = 1'b0;
    logic           mod_clr;
    logic           busy;
    logic           res_valid;
    logic [1:0]     res_ch;
    logic [CW-1:0]  res_data;
    logic [CW:0]    res_code;
    logic           res_last;
    logic           overrun;

    sd_scan_ctrl #(.NUM(NUM), .OSR(OSR), .SETTLE(SETTLE)) dut (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .sd_in     (sd_in),
        .mod_clr   (mod_clr),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_data  (res_data),
        .res_code  (res_code),
        .res_last  (res_last),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int data;
        int code;
        int last;
    } exp_t;

    exp_t q[$];
    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   exp_overrun = 0;
    int   ready_mode  = 0;
    int   held        = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Ready driver: 0 always ready, 1 random, 2 stalled,
    // 3 stall 5 cycles on ch1, 4 stall whenever ch2 is presented.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                2: res_ready = 1'b0;
                3: begin
                    if (res_valid && res_ch == 2'd1 && held < 5) begin
                        res_ready = 1'b0;
                        held++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: res_ready = !(res_valid && res_ch == 2'd2);
            endcase
        end
    end

    // Monitor: compare on handshake, check stability while stalled.
    bit            have_prev = 0;
    logic [1:0]    prev_ch;
    logic [CW-1:0] prev_data;
    always @(negedge clock) begin
        if (aclr_n && res_valid) begin
            if (have_prev) begin
                check("held_ch", res_ch, prev_ch);
                check("held_data", res_data, prev_data);
            end
            if (q.size() == 0) begin
                check("unexpected_valid", res_valid, 0);
                have_prev = 0;
            end else if (res_ready) begin
                exp_t e;
                e = q.pop_front();
                check("res_ch", res_ch, e.ch);
                check("res_data", res_data, e.data);
                check("res_code", $signed(res_code), e.code);
                check("res_last", res_last, e.last);
                have_prev = 0;
            end else begin
                have_prev = 1;
                prev_ch   = res_ch;
                prev_data = res_data;
            end
        end else begin
            have_prev = 0;
        end
    end

    // One acquisition of nwin windows. pat: 0 random, 1 all ones, 2 mixed.
    // abort_at >= 0 aborts in that INTEG cycle of the first window.
    // hold_win >= 0 switches to always-ready after that window ends.
    task automatic acquire(input int nwin, input int pat, input int abort_at,
                           input int hold_win);
        int sum [NUM];
        start = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        exp_overrun = 0;
        check("mod_clr_released", mod_clr, 0);
        check("busy_started", busy, 1);
        check("overrun_cleared", overrun, 0);
        repeat (SETTLE) begin
            sd_in = NUM'($urandom);
            @(posedge clock);
            #1;
        end
        for (int w = 0; w < nwin; w++) begin
            bit loaded;
            loaded = 0;
            for (int i = 0; i < NUM; i++) sum[i] = 0;
            for (int k = 0; k < OSR; k++) begin
                case (pat)
                    1:       sd_in = '1;
                    2:       sd_in = {1'b0, 1'b1, 1'b0, 1'((k % 2) == 0)};
                    default: sd_in = NUM'($urandom);
                endcase
                for (int i = 0; i < NUM; i++) sum[i] += int'(sd_in[i]);
                if (w == 0 && k == abort_at) begin
                    abort = 1'b1;
                    @(posedge clock);
                    #1;
                    abort = 1'b0;
                    check("abort_mod_clr", mod_clr, 1);
                    check("abort_busy", busy, (q.size() != 0) ? 1 : 0);
                    return;
                end
                if (k == OSR - 1) begin
                    cont = (w < nwin - 1) ? 1'b1 : 1'b0;
                    // The bank is free only if every earlier result was taken
                    // before this cycle.
                    if (q.size() == 0) begin
                        loaded = 1;
                        for (int i = 0; i < NUM; i++) begin
                            exp_t e;
                            e.ch   = i;
                            e.data = sum[i];
                            e.code = 2 * sum[i] - OSR;
                            e.last = (i == NUM - 1) ? 1 : 0;
                            q.push_back(e);
                        end
                    end else begin
                        exp_overrun = 1;
                    end
                end
                @(posedge clock);
                #1;
            end
            cont = 1'b0;
            if (loaded) begin
                check("first_valid", res_valid, 1);
                check("first_ch", res_ch, 0);
            end
            check("overrun", overrun, exp_overrun);
            if (w == hold_win) ready_mode = 0;
        end
        check("mod_clr_end", mod_clr, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || res_valid) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_timeout", (n < 300) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_mod_clr", mod_clr, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_ch", res_ch, 0);
        check("rst_data", res_data, 0);
        check("rst_code", $signed(res_code), -OSR);
        check("rst_last", res_last, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clock);
        aclr_n = 1'b1;
        @(posedge clock);
        #1;

        // T1 all ones
        ready_mode = 0;
        acquire(1, 1, -1, -1);
        wait_drain();

        // T2 mixed constant/toggling channels
        acquire(1, 2, -1, -1);
        wait_drain();

        // T3 backpressure on ch1
        held       = 0;
        ready_mode = 3;
        acquire(1, 0, -1, -1);
        wait_drain();

        // Random windows, random ready, single and continuous
        for (int r = 0; r < 5; r++) begin
            ready_mode = 1;
            acquire($urandom_range(1, 3), 0, -1, -1);
            wait_drain();
        end

        // T4 continuous with the drain stalled across the second window end
        ready_mode = 2;
        acquire(3, 0, -1, 1);
        wait_drain();
        check("overrun_sticky", overrun, 1);
        ready_mode = 0;
        acquire(1, 1, -1, -1);
        wait_drain();

        // T5 abort mid-window
        acquire(1, 0, 7, -1);
        repeat (OSR + 4) @(posedge clock);
        #1;
        check("abort_no_valid", res_valid, 0);
        acquire(1, 1, -1, -1);
        wait_drain();

        // T6 async reset while ch2 is presented
        ready_mode = 4;
        acquire(1, 1, -1, -1);
        begin
            int n;
            n = 0;
            while (!(res_valid && res_ch == 2'd2) && n < 50) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("reach_ch2", (n < 50) ? 1 : 0, 1);
        end
        #2;
        aclr_n = 1'b0;
        #1;
        check("arst_mod_clr", mod_clr, 1);
        check("arst_busy", busy, 0);
        check("arst_valid", res_valid, 0);
        check("arst_ch", res_ch, 0);
        check("arst_data", res_data, 0);
        check("arst_last", res_last, 0);
        check("arst_overrun", overrun, 0);
        q.delete();
        ready_mode = 0;
        @(negedge clock);
        aclr_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("arst_no_stale", res_valid, 0);
        acquire(1, 1, -1, -1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
